// File: rtl/prime_display_pkg.sv
// Shared types, glyph constants and the double-dabble step for prime_display.
package prime_display_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      LATCH
   } state_t;

   localparam int unsigned BIN_W   = 9;
   localparam int unsigned BCD_W   = 12;
   localparam int unsigned SHIFT_W = BCD_W + BIN_W;

   // Display codes fed to seg7_decode; 0-9 are plain decimal digits.
   localparam logic [3:0] CODE_P     = 4'hA;
   localparam logic [3:0] CODE_DASH  = 4'hB;
   localparam logic [3:0] CODE_E     = 4'hC;
   localparam logic [3:0] CODE_BLANK = 4'hF;

   // Active-low segment patterns, bit 0 = a .. bit 6 = g.
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_P     = 7'h0C;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_E     = 7'h06;

   // Digit table, index 9 first in the concatenation.
   localparam logic [9:0][6:0] DIGIT_SEG = {
      7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
      7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left.
   function automatic logic [SHIFT_W-1:0] dabble_step(input logic [SHIFT_W-1:0] s);
      logic [SHIFT_W-1:0] t;
      t = s;
      for (int unsigned i = 0; i < BCD_W / 4; i++) begin
         if (t[BIN_W + 4*i +: 4] >= 4'd5) begin
            t[BIN_W + 4*i +: 4] = t[BIN_W + 4*i +: 4] + 4'd3;
         end
      end
      return {t[SHIFT_W-2:0], 1'b0};
   endfunction

endpackage

// File: rtl/prime_display_if.sv
// Operand/flag inputs and display outputs of prime_display.
interface prime_display_if;
   import prime_display_pkg::*;

   logic [BIN_W-1:0] number;
   logic             result;
   logic [6:0]       seg;
   logic             dp;
   logic [3:0]       an;
   logic             busy;

   modport master (
      output number, result,
      input  seg, dp, an, busy
   );

   modport slave (
      input  number, result,
      output seg, dp, an, busy
   );
endinterface

// File: rtl/prime_display_seg7_decode.sv
// Display code to active-low 7-segment pattern.
module seg7_decode
   import prime_display_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   // Table lookup; unknown codes render blank.
   always_comb begin
      seg = SEG_BLANK;
      case (code)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
         4'd5, 4'd6, 4'd7, 4'd8, 4'd9: seg = DIGIT_SEG[code];
         CODE_P:                       seg = SEG_P;
         CODE_DASH:                    seg = SEG_DASH;
         CODE_E:                       seg = SEG_E;
         default:                      seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/prime_display.sv
// Binary-to-BCD conversion of the operand plus a multiplexed 4-digit display:
// digit 3 shows prime status, digits 2..0 the decimal value.
module prime_display
   import prime_display_pkg::*;
#(
   parameter int unsigned DIGIT_TICKS = 100000,
   parameter int unsigned PRIME_MAX   = 360
) (
   input  logic            clk,
   input  logic            reset,
   prime_display_if.slave  bus
);

   localparam int unsigned TICK_W    = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
   localparam logic [3:0]  CONV_LAST = 4'd8;

   state_t             state;
   logic [SHIFT_W-1:0] shift_q;
   logic [BIN_W-1:0]   last_q;
   logic [BIN_W-1:0]   cap_q;
   logic [3:0]         cnt;
   logic               force_q;
   logic               busy_q;
   logic               prime_q;
   logic [3:0][3:0]    disp_q;

   logic [TICK_W-1:0]  tick;
   logic [1:0]         idx;
   logic [6:0]         seg_q;
   logic [3:0]         an_q;
   logic [6:0]         glyph;

   logic [3:0]         hund;
   logic [3:0]         tens;
   logic [3:0]         ones;

   assign hund = shift_q[BIN_W + 8 +: 4];
   assign tens = shift_q[BIN_W + 4 +: 4];
   assign ones = shift_q[BIN_W     +: 4];

   // Capture / convert / latch sequencer with the double-dabble datapath.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         shift_q <= '0;
         last_q  <= '0;
         cap_q   <= '0;
         cnt     <= '0;
         force_q <= 1'b1;
         busy_q  <= 1'b0;
         prime_q <= 1'b0;
         disp_q  <= {4{CODE_BLANK}};
      end else begin
         unique case (state)
            IDLE: begin
               if ((bus.number != last_q) || force_q) begin
                  shift_q <= {{BCD_W{1'b0}}, bus.number};
                  last_q  <= bus.number;
                  cap_q   <= bus.number;
                  cnt     <= '0;
                  force_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state   <= CONV;
               end
            end
            CONV: begin
               shift_q <= dabble_step(shift_q);
               // The prime flag lags the operand by one cycle, so it is
               // sampled on the second conversion edge.
               if (cnt == 4'd1) begin
                  prime_q <= bus.result;
               end
               if (cnt == CONV_LAST) begin
                  state <= LATCH;
               end
               cnt <= cnt + 4'd1;
            end
            LATCH: begin
               if (cap_q > BIN_W'(PRIME_MAX)) begin
                  disp_q[3] <= CODE_E;
               end else if (prime_q) begin
                  disp_q[3] <= CODE_P;
               end else begin
                  disp_q[3] <= CODE_DASH;
               end
               disp_q[2] <= (hund == 4'd0) ? CODE_BLANK : hund;
               disp_q[1] <= ((hund == 4'd0) && (tens == 4'd0)) ? CODE_BLANK : tens;
               disp_q[0] <= ones;
               busy_q    <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   seg7_decode u_decode (
      .code (disp_q[idx]),
      .seg  (glyph)
   );

   // Digit scan: anode and segments registered together from the same index.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick  <= '0;
         idx   <= '0;
         seg_q <= SEG_BLANK;
         an_q  <= '1;
      end else begin
         if (tick == TICK_W'(DIGIT_TICKS - 1)) begin
            tick <= '0;
            idx  <= idx + 2'd1;
         end else begin
            tick <= tick + 1'b1;
         end
         seg_q <= glyph;
         an_q  <= ~(4'b0001 << idx);
      end
   end

   assign bus.seg  = seg_q;
   assign bus.an   = an_q;
   assign bus.dp   = 1'b1;
   assign bus.busy = busy_q;

endmodule

// File: tb/tb_prime_display.sv
// Directed bench for prime_display with a scoreboard of expected digit glyphs.
module tb_prime_display;

   logic clk;
   logic reset;
   logic force_prime;

   int n_checks;
   int n_fail;

   logic [3:0][6:0] exp_q[$];

   prime_display_if bus ();

   prime_display #(
      .DIGIT_TICKS (4),
      .PRIME_MAX   (360)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit is_prime(input int n);
      if (n < 2) return 1'b0;
      for (int d = 2; d * d <= n; d++) begin
         if (n % d == 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Upstream prime stage: registered flag, one cycle behind the operand.
   always @(posedge clk) begin
      bus.result <= force_prime ? 1'b1 : is_prime(int'(bus.number));
   end

   // Segment patterns written active-high (gfedcba) and inverted for the pins.
   function automatic logic [6:0] dig_glyph(input int d);
      logic [6:0] hi;
      case (d)
         0: hi = 7'h3F;
         1: hi = 7'h06;
         2: hi = 7'h5B;
         3: hi = 7'h4F;
         4: hi = 7'h66;
         5: hi = 7'h6D;
         6: hi = 7'h7D;
         7: hi = 7'h07;
         8: hi = 7'h7F;
         default: hi = 7'h6F;
      endcase
      return ~hi;
   endfunction

   localparam logic [6:0] G_BLANK = ~7'h00;
   localparam logic [6:0] G_P     = ~7'h73;
   localparam logic [6:0] G_DASH  = ~7'h40;
   localparam logic [6:0] G_E     = ~7'h79;

   function automatic logic [3:0][6:0] model(input int n, input bit fp);
      logic [3:0][6:0] m;
      int h, t, o;
      h = n / 100;
      t = (n / 10) % 10;
      o = n % 10;
      if (n > 360)                 m[3] = G_E;
      else if (fp || is_prime(n))  m[3] = G_P;
      else                         m[3] = G_DASH;
      m[2] = (h == 0) ? G_BLANK : dig_glyph(h);
      m[1] = (h == 0 && t == 0) ? G_BLANK : dig_glyph(t);
      m[0] = dig_glyph(o);
      return m;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int n);
      bus.number = n[8:0];
      exp_q.push_back(model(n, force_prime));
   endtask

   task automatic wait_busy_rise();
      int n = 0;
      while (bus.busy !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("busy_rise", {31'd0, bus.busy}, 32'd1);
   endtask

   task automatic count_busy(input int exp_cycles);
      int n = 0;
      while (bus.busy === 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("busy_len", n, exp_cycles);
   endtask

   // Samples the scan for ncyc cycles against the scoreboard head, then retires it.
   task automatic scan_check(input int ncyc, input bit busy_hi, input bit need_all);
      logic [3:0][6:0] e;
      logic [3:0] seen;
      int idx;
      bit valid;
      check("sb_nonempty", exp_q.size(), (exp_q.size() == 0) ? 1 : exp_q.size());
      if (exp_q.size() == 0) return;
      e = exp_q[0];
      seen = '0;
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clk);
         valid = 1'b1;
         idx = 0;
         case (bus.an)
            4'b1110: idx = 0;
            4'b1101: idx = 1;
            4'b1011: idx = 2;
            4'b0111: idx = 3;
            default: valid = 1'b0;
         endcase
         check("an_onehot", {31'd0, valid}, 32'd1);
         if (valid) begin
            check($sformatf("seg_digit%0d", idx), {25'd0, bus.seg}, {25'd0, e[idx]});
            seen[idx] = 1'b1;
         end
         check("dp_off", {31'd0, bus.dp}, 32'd1);
         if (busy_hi) check("busy_hold", {31'd0, bus.busy}, 32'd1);
      end
      if (need_all) check("digits_seen", {28'd0, seen}, 32'hF);
      void'(exp_q.pop_front());
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_seg"},  {25'd0, bus.seg},  32'h7F);
      check({tag, "_an"},   {28'd0, bus.an},   32'hF);
      check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
      check({tag, "_dp"},   {31'd0, bus.dp},   32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      force_prime = 1'b0;
      reset       = 1'b0;
      bus.number  = 9'd7;

      // Reset held with clocks running, then release with 7.
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      drive(7);
      reset = 1'b1;
      wait_busy_rise();
      count_busy(10);
      scan_check(20, 1'b0, 1'b1);

      // 360 is in range and composite; 0 shows a single digit.
      drive(360);
      wait_busy_rise();
      count_busy(10);
      scan_check(20, 1'b0, 1'b1);
      drive(0);
      wait_busy_rise();
      count_busy(10);
      scan_check(20, 1'b0, 1'b1);

      // Out of range shows E even with the prime flag forced high.
      force_prime = 1'b1;
      drive(361);
      wait_busy_rise();
      count_busy(10);
      scan_check(20, 1'b0, 1'b1);
      drive(511);
      wait_busy_rise();
      count_busy(10);
      scan_check(20, 1'b0, 1'b1);
      force_prime = 1'b0;

      // Operand change mid-conversion: 13 completes, then 100 restarts.
      drive(13);
      repeat (4) @(negedge clk);
      drive(100);
      count_busy(7);
      scan_check(10, 1'b1, 1'b0);
      @(negedge clk);
      check("busy_fall_100", {31'd0, bus.busy}, 32'd0);
      scan_check(20, 1'b0, 1'b1);

      // Steady operand: anode rotation, 4 cycles per digit, then wrap.
      begin
         int n = 0;
         logic [3:0] prev;
         prev = bus.an;
         @(negedge clk);
         while (!(prev == 4'b0111 && bus.an == 4'b1110) && n < 40) begin
            prev = bus.an;
            @(negedge clk);
            n++;
         end
         check("scan_sync", {28'd0, bus.an}, 32'hE);
         for (int k = 1; k <= 16; k++) begin
            logic [3:0] exp_an;
            @(negedge clk);
            exp_an = ~(4'b0001 << ((k / 4) % 4));
            check($sformatf("an_seq%0d", k), {28'd0, bus.an}, {28'd0, exp_an});
         end
      end

      // Asynchronous reset mid-conversion, then reconversion of the same operand.
      drive(257);
      wait_busy_rise();
      repeat (4) @(negedge clk);
      #1 reset = 1'b0;
      #1 check_reset_outputs("midreset");
      repeat (2) @(negedge clk);
      check_reset_outputs("midreset_hold");
      reset = 1'b1;
      wait_busy_rise();
      count_busy(10);
      scan_check(20, 1'b0, 1'b1);

      check("sb_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
